// File: rtl/fft128_seq_if.sv
// Handshake and bus bundle between the FFT sequencer and its neighbours
// (frame source, sample RAM, butterfly unit, twiddle ROM, demapper).
interface fft128_seq_if;
    logic       Pushin;
    logic       FirstData;
    logic       InRdy;
    logic       WrEn;
    logic [6:0] WrAddr;
    logic       BfValid;
    logic [6:0] BfAddrA;
    logic [6:0] BfAddrB;
    logic [5:0] TwIdx;
    logic [2:0] BfStage;
    logic       RdEn;
    logic [6:0] RdAddr;
    logic       PushOut;
    logic       OutFirst;
    logic       OutLast;
    logic       Overrun;
    logic       Busy;

    modport slave (
        input  Pushin, FirstData,
        output InRdy, WrEn, WrAddr, BfValid, BfAddrA, BfAddrB, TwIdx, BfStage,
               RdEn, RdAddr, PushOut, OutFirst, OutLast, Overrun, Busy
    );

    modport master (
        output Pushin, FirstData,
        input  InRdy, WrEn, WrAddr, BfValid, BfAddrA, BfAddrB, TwIdx, BfStage,
               RdEn, RdAddr, PushOut, OutFirst, OutLast, Overrun, Busy
    );
endinterface

// File: rtl/fft128_seq.sv
// Sequencer for the 128-point radix-2 in-place FFT: bit-reversed frame load,
// 7x64 butterfly schedule with a writeback drain gap per stage, natural-order
// unload. Owns no arithmetic.
//
// state   | meaning
// IDLE    | waiting for a sample flagged FirstData
// LOAD    | writing samples 1..127 bit-reversed into the sample RAM
// COMPUTE | issuing 64 butterflies of the current stage, one per cycle
// DRAIN   | BF_LAT quiet cycles so stage writebacks land before next reads
// UNLOAD  | reading bins 0..127, then waiting RD_LAT for the last bin
module fft128_seq #(
    parameter int BF_LAT = 3,
    parameter int RD_LAT = 1
) (
    input  logic        Clk,
    input  logic        Reset,
    fft128_seq_if.slave bus
);
    localparam int UW = $clog2(128 + RD_LAT);

    typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, DRAIN, UNLOAD} state_t;

    state_t            state;
    logic [6:0]        cnt;
    logic [5:0]        bfly;
    logic [2:0]        stage;
    logic [7:0]        drain_cnt;
    logic [UW-1:0]     rd_cnt;
    logic [RD_LAT-1:0] pipe_v;
    logic [RD_LAT-1:0] pipe_f;
    logic [RD_LAT-1:0] pipe_l;

    logic       in_rdy;
    logic       accept;
    logic       rd_en;
    logic       bf_valid;
    logic [6:0] mask7;
    logic [6:0] bfly7;
    logic [6:0] addr_a;
    logic [6:0] half;

    function automatic logic [6:0] bitrev7(input logic [6:0] v);
        logic [6:0] r;
        for (int i = 0; i < 7; i++) r[i] = v[6-i];
        return r;
    endfunction

    // FirstData always wins in LOAD: it restarts the frame at address 0.
    assign in_rdy   = (state == IDLE) || (state == LOAD);
    assign accept   = bus.Pushin && (((state == IDLE) && bus.FirstData) || (state == LOAD));
    assign rd_en    = (state == UNLOAD) && (rd_cnt < UW'(128));
    assign bf_valid = (state == COMPUTE);

    // Insert a zero bit at position 'stage' of b: grp*2*half + pos.
    assign half   = 7'd1 << stage;
    assign mask7  = half - 7'd1;
    assign bfly7  = {1'b0, bfly};
    assign addr_a = ((bfly7 & ~mask7) << 1) | (bfly7 & mask7);

    assign bus.InRdy    = in_rdy;
    assign bus.WrEn     = accept;
    assign bus.WrAddr   = (accept && !bus.FirstData) ? bitrev7(cnt) : 7'd0;
    assign bus.BfValid  = bf_valid;
    assign bus.BfAddrA  = bf_valid ? addr_a : 7'd0;
    assign bus.BfAddrB  = bf_valid ? (addr_a + half) : 7'd0;
    assign bus.TwIdx    = bf_valid ? ((bfly & mask7[5:0]) << (3'd6 - stage)) : 6'd0;
    assign bus.BfStage  = stage;
    assign bus.RdEn     = rd_en;
    assign bus.RdAddr   = rd_en ? rd_cnt[6:0] : 7'd0;
    assign bus.PushOut  = pipe_v[RD_LAT-1];
    assign bus.OutFirst = pipe_f[RD_LAT-1];
    assign bus.OutLast  = pipe_l[RD_LAT-1];
    assign bus.Overrun  = bus.Pushin && !in_rdy;
    assign bus.Busy     = (state != IDLE);

    // Main sequencer plus the RD_LAT delay line that marks valid RAM output.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state     <= IDLE;
            cnt       <= '0;
            bfly      <= '0;
            stage     <= '0;
            drain_cnt <= '0;
            rd_cnt    <= '0;
            pipe_v    <= '0;
            pipe_f    <= '0;
            pipe_l    <= '0;
        end else begin
            pipe_v <= (pipe_v << 1) | RD_LAT'(rd_en);
            pipe_f <= (pipe_f << 1) | RD_LAT'(rd_en && (rd_cnt == UW'(0)));
            pipe_l <= (pipe_l << 1) | RD_LAT'(rd_en && (rd_cnt == UW'(127)));
            case (state)
                IDLE: begin
                    if (bus.Pushin && bus.FirstData) begin
                        state <= LOAD;
                        cnt   <= 7'd1;
                    end
                end
                LOAD: begin
                    if (bus.Pushin) begin
                        if (bus.FirstData) begin
                            cnt <= 7'd1;
                        end else if (cnt == 7'd127) begin
                            state <= COMPUTE;
                            cnt   <= '0;
                            bfly  <= '0;
                            stage <= '0;
                        end else begin
                            cnt <= cnt + 7'd1;
                        end
                    end
                end
                COMPUTE: begin
                    bfly <= bfly + 6'd1;
                    if (bfly == 6'd63) begin
                        state     <= DRAIN;
                        drain_cnt <= 8'(BF_LAT - 1);
                    end
                end
                DRAIN: begin
                    if (drain_cnt == 8'd0) begin
                        if (stage == 3'd6) begin
                            state  <= UNLOAD;
                            stage  <= '0;
                            rd_cnt <= '0;
                        end else begin
                            state <= COMPUTE;
                            stage <= stage + 3'd1;
                        end
                    end else begin
                        drain_cnt <= drain_cnt - 8'd1;
                    end
                end
                UNLOAD: begin
                    if (rd_cnt == UW'(127 + RD_LAT)) begin
                        state  <= IDLE;
                        rd_cnt <= '0;
                    end else begin
                        rd_cnt <= rd_cnt + UW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fft128_seq.sv
// Directed bench for fft128_seq with BF_LAT=3, RD_LAT=1.
module tb_fft128_seq;
    logic Clk = 1'b0;
    logic Reset = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   last_wr = 0;
    int   first_po = 0;

    fft128_seq_if bus();

    fft128_seq #(.BF_LAT(3), .RD_LAT(1)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #2;
        cyc++;
    endtask

    function automatic int brev(input int v);
        int r = 0;
        for (int k = 0; k < 7; k++) if (v[k]) r |= (1 << (6 - k));
        return r;
    endfunction

    task automatic send(input bit f, input int exp_addr);
        tick();
        bus.Pushin = 1'b1;
        bus.FirstData = f;
        #1;
        chk("wr_en", bus.WrEn, 1);
        chk("wr_addr", bus.WrAddr, exp_addr);
        chk("load_bfvalid", bus.BfValid, 0);
        chk("load_overrun", bus.Overrun, 0);
        last_wr = cyc;
    endtask

    task automatic load_rest();
        for (int i = 1; i < 128; i++) begin
            send(1'b0, brev(i));
            if (i == 1)   chk("wr_addr_1", bus.WrAddr, 64);
            if (i == 2)   chk("wr_addr_2", bus.WrAddr, 32);
            if (i == 3)   chk("wr_addr_3", bus.WrAddr, 96);
            if (i == 127) chk("wr_addr_127", bus.WrAddr, 127);
        end
    endtask

    task automatic run_sched(input bit inject);
        int half, pos, grp, ea;
        for (int s = 0; s < 7; s++) begin
            for (int b = 0; b < 64; b++) begin
                tick();
                bus.Pushin = inject && (s == 2) && (b == 10);
                bus.FirstData = 1'b0;
                #1;
                half = 1 << s;
                pos  = b % half;
                grp  = b / half;
                ea   = grp * 2 * half + pos;
                chk("bf_valid", bus.BfValid, 1);
                chk("bf_stage", bus.BfStage, s);
                chk("bf_addr_a", bus.BfAddrA, ea);
                chk("bf_addr_b", bus.BfAddrB, ea + half);
                chk("tw_idx", bus.TwIdx, pos * (64 / half));
                chk("bf_wr_en", bus.WrEn, 0);
                chk("bf_rd_en", bus.RdEn, 0);
                chk("bf_overrun", bus.Overrun, bus.Pushin ? 1 : 0);
                if (s == 0 && b == 5) begin
                    chk("s0b5_a", bus.BfAddrA, 10);
                    chk("s0b5_b", bus.BfAddrB, 11);
                    chk("s0b5_tw", bus.TwIdx, 0);
                end
                if (s == 3 && b == 13) begin
                    chk("s3b13_a", bus.BfAddrA, 21);
                    chk("s3b13_b", bus.BfAddrB, 29);
                    chk("s3b13_tw", bus.TwIdx, 40);
                end
                if (s == 6 && b == 63) begin
                    chk("s6b63_a", bus.BfAddrA, 63);
                    chk("s6b63_b", bus.BfAddrB, 127);
                    chk("s6b63_tw", bus.TwIdx, 63);
                end
            end
            for (int d = 0; d < 3; d++) begin
                tick();
                bus.Pushin = inject && (s == 4) && (d == 1);
                #1;
                chk("drain_bfvalid", bus.BfValid, 0);
                chk("drain_rd_en", bus.RdEn, 0);
                chk("drain_busy", bus.Busy, 1);
                chk("drain_wr_en", bus.WrEn, 0);
                chk("drain_overrun", bus.Overrun, bus.Pushin ? 1 : 0);
            end
        end
        for (int i = 0; i < 128; i++) begin
            tick();
            bus.Pushin = inject && (i == 5);
            #1;
            chk("rd_en", bus.RdEn, 1);
            chk("rd_addr", bus.RdAddr, i);
            chk("push_out", bus.PushOut, (i >= 1) ? 1 : 0);
            chk("out_first", bus.OutFirst, (i == 1) ? 1 : 0);
            chk("out_last", bus.OutLast, 0);
            chk("ul_bfvalid", bus.BfValid, 0);
            chk("ul_wr_en", bus.WrEn, 0);
            chk("ul_overrun", bus.Overrun, bus.Pushin ? 1 : 0);
            if (i == 1) first_po = cyc;
        end
        tick();
        bus.Pushin = 1'b0;
        #1;
        chk("tail_rd_en", bus.RdEn, 0);
        chk("tail_push_out", bus.PushOut, 1);
        chk("tail_out_last", bus.OutLast, 1);
        chk("tail_out_first", bus.OutFirst, 0);
        chk("tail_busy", bus.Busy, 1);
        tick();
        #1;
        chk("end_push_out", bus.PushOut, 0);
        chk("end_busy", bus.Busy, 0);
        chk("end_in_rdy", bus.InRdy, 1);
        chk("latency", first_po - last_wr - 1, 470);
    endtask

    initial begin
        bus.Pushin = 1'b0;
        bus.FirstData = 1'b0;

        // Reset state
        tick();
        tick();
        #1;
        chk("rst_in_rdy", bus.InRdy, 1);
        chk("rst_busy", bus.Busy, 0);
        chk("rst_wr_en", bus.WrEn, 0);
        chk("rst_bfvalid", bus.BfValid, 0);
        chk("rst_rd_en", bus.RdEn, 0);
        chk("rst_push_out", bus.PushOut, 0);
        chk("rst_overrun", bus.Overrun, 0);
        Reset = 1'b1;

        // Pushin without FirstData in IDLE is ignored
        tick();
        bus.Pushin = 1'b1;
        bus.FirstData = 1'b0;
        #1;
        chk("idle_nofirst_wr_en", bus.WrEn, 0);
        chk("idle_nofirst_overrun", bus.Overrun, 0);
        tick();
        bus.Pushin = 1'b0;
        #1;
        chk("idle_nofirst_busy", bus.Busy, 0);

        // Frame 1: back-to-back load, full schedule, unload
        send(1'b1, 0);
        load_rest();
        run_sched(1'b0);

        // Frame 2: reset during stage 3 aborts the frame
        send(1'b1, 0);
        load_rest();
        for (int k = 0; k < 212; k++) begin
            tick();
            bus.Pushin = 1'b0;
        end
        #1;
        chk("pre_rst_stage", bus.BfStage, 3);
        chk("pre_rst_bfvalid", bus.BfValid, 1);
        Reset = 1'b0;
        tick();
        Reset = 1'b1;
        #1;
        chk("abort_busy", bus.Busy, 0);
        chk("abort_in_rdy", bus.InRdy, 1);
        chk("abort_bfvalid", bus.BfValid, 0);
        for (int k = 0; k < 300; k++) begin
            tick();
            #1;
            chk("abort_no_push_out", bus.PushOut, 0);
        end

        // Frame 3: FirstData again at sample 50, a gap, then overruns during processing
        send(1'b1, 0);
        for (int i = 1; i < 50; i++) send(1'b0, brev(i));
        send(1'b1, 0);
        tick();
        bus.Pushin = 1'b0;
        #1;
        chk("gap_wr_en", bus.WrEn, 0);
        chk("gap_in_rdy", bus.InRdy, 1);
        chk("gap_busy", bus.Busy, 1);
        load_rest();
        run_sched(1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
